// File: rtl/multichannel_ds_modulator_if.sv
// Bus bundle for multichannel_ds_modulator.
//   master : sample/coefficient source (drives en, u, coeffs, test hooks; receives codes)
//   slave  : the modulator itself
// Signals:
//   en               advance enable
//   u                packed unsigned channel samples, channel c at [c*IN_BITS +: IN_BITS]
//   coeffs           packed signed taps, c_k at [(k-1)*COEFF_BITS +: COEFF_BITS]
//   force_err        overrides the error stored at quantisation
//   forced_err_value value stored while force_err is high
//   reset_lfsr       reloads the dither LFSR seed (dither builds only)
//   y, y_channel     quantised code and its channel
//   y_valid          one-cycle strobe qualifying y, y_channel, y_sat
//   y_sat            code was clamped
interface multichannel_ds_modulator_if #(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned ORDER        = 3,
  parameter int unsigned IN_BITS      = 16,
  parameter int unsigned FRAC_BITS    = 8,
  parameter int unsigned OUT_BITS     = 9,
  parameter int unsigned COEFF_BITS   = 3
) ();
  localparam int unsigned ChW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic                            en;
  logic [NUM_CHANNELS*IN_BITS-1:0] u;
  logic [ORDER*COEFF_BITS-1:0]     coeffs;
  logic                            force_err;
  logic [FRAC_BITS-1:0]            forced_err_value;
  logic                            reset_lfsr;
  logic [OUT_BITS-1:0]             y;
  logic [ChW-1:0]                  y_channel;
  logic                            y_valid;
  logic                            y_sat;

  modport master (
    output en, u, coeffs, force_err, forced_err_value, reset_lfsr,
    input  y, y_channel, y_valid, y_sat
  );

  modport slave (
    input  en, u, coeffs, force_err, forced_err_value, reset_lfsr,
    output y, y_channel, y_valid, y_sat
  );
endinterface

// File: rtl/multichannel_ds_modulator.sv
// Time-multiplexed error-feedback delta-sigma modulator for NUM_CHANNELS channels with a
// runtime-programmable NTF of order ORDER (NTF = 1 - sum c_k z^-k).
// One shared datapath walks each channel through ORDER+1 steps: step 0 loads the sample,
// steps 1..ORDER accumulate c_k * e[ch][k], step ORDER quantises and updates the history.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset (overrides en)
//   ds_if  slave side of multichannel_ds_modulator_if (samples, taps, hooks, output code)
// Build option: define DS_DITHER_EN to add 16-bit Galois LFSR dither before quantisation.
module multichannel_ds_modulator #(
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned ORDER        = 3,
  parameter int unsigned IN_BITS      = 16,
  parameter int unsigned FRAC_BITS    = 8,
  parameter int unsigned OUT_BITS     = 9,
  parameter int unsigned COEFF_BITS   = 3
) (
  input logic                        clk,
  input logic                        reset,
  multichannel_ds_modulator_if.slave ds_if
);
  localparam int unsigned ChW  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned StW  = $clog2(ORDER + 1);
  localparam int unsigned AccW = IN_BITS + COEFF_BITS + $clog2(ORDER + 1) + 2;
  localparam logic signed [AccW-1:0] YMax = AccW'((64'd1 << OUT_BITS) - 64'd1);

  logic [StW-1:0]               st_q, st_d;
  logic [ChW-1:0]               ch_q, ch_d;
  logic signed [AccW-1:0]       acc_q, acc_d;
  logic signed [COEFF_BITS-1:0] coeff_q [ORDER];
  logic signed [COEFF_BITS-1:0] coeff_d [ORDER];
  logic [FRAC_BITS-1:0]         e_q [NUM_CHANNELS][ORDER];
  logic [FRAC_BITS-1:0]         e_d [NUM_CHANNELS][ORDER];
  logic [OUT_BITS-1:0]          y_q, y_d;
  logic [ChW-1:0]               y_ch_q, y_ch_d;
  logic                         y_sat_q, y_sat_d;
  logic                         pending_q, pending_d;

  logic                         last_step, last_ch;
  logic [IN_BITS-1:0]           u_sel;
  logic signed [COEFF_BITS-1:0] coeff_sel;
  logic [FRAC_BITS-1:0]         err_sel;
  logic signed [AccW-1:0]       coeff_ext, err_ext, prod, acc_sum, dither, w, q;
  logic [OUT_BITS-1:0]          y_new;
  logic                         sat_new;
  logic [FRAC_BITS-1:0]         e_new;

`ifdef DS_DITHER_EN
  localparam logic [15:0] LfsrMask = 16'hB400;
  localparam logic [15:0] LfsrSeed = 16'hACE1;

  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset || ds_if.reset_lfsr) begin
      lfsr_q <= LfsrSeed;
    end else if (ds_if.en && last_step) begin
      lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrMask) : (lfsr_q >> 1);
    end
  end

  // Centre the dither around zero: d in [-2^(F-1), 2^(F-1)-1].
  assign dither = {{(AccW-FRAC_BITS){1'b0}}, lfsr_q[FRAC_BITS-1:0]}
                - AccW'(64'd1 << (FRAC_BITS - 1));
`else
  logic unused_reset_lfsr;
  assign unused_reset_lfsr = ds_if.reset_lfsr;
  assign dither = '0;
`endif

  assign last_step = (st_q == StW'(ORDER));
  assign last_ch   = (ch_q == ChW'(NUM_CHANNELS - 1));

  // Shared datapath: operand selection, tap product and quantiser.
  always_comb begin
    u_sel     = '0;
    coeff_sel = '0;
    err_sel   = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_q == ChW'(c)) u_sel = ds_if.u[c*IN_BITS +: IN_BITS];
    end
    for (int k = 0; k < ORDER; k++) begin
      if (st_q == StW'(k + 1)) begin
        coeff_sel = coeff_q[k];
        err_sel   = e_q[ch_q][k];
      end
    end
    coeff_ext = {{(AccW-COEFF_BITS){coeff_sel[COEFF_BITS-1]}}, coeff_sel};
    err_ext   = {{(AccW-FRAC_BITS){1'b0}}, err_sel};
    prod      = coeff_ext * err_ext;
    acc_sum   = acc_q + prod;
    w         = acc_sum + dither;
    q         = w >>> FRAC_BITS;
    if (q[AccW-1]) begin
      y_new   = '0;
      sat_new = 1'b1;
    end else if (q > YMax) begin
      y_new   = '1;
      sat_new = 1'b1;
    end else begin
      y_new   = q[OUT_BITS-1:0];
      sat_new = 1'b0;
    end
    // Error always comes from the unclamped sum so clamping does not corrupt the noise shaping.
    e_new = ds_if.force_err ? ds_if.forced_err_value : w[FRAC_BITS-1:0];
  end

  // Sequencer and state update.
  always_comb begin
    st_d      = st_q;
    ch_d      = ch_q;
    acc_d     = acc_q;
    coeff_d   = coeff_q;
    e_d       = e_q;
    y_d       = y_q;
    y_ch_d    = y_ch_q;
    y_sat_d   = y_sat_q;
    pending_d = pending_q;
    if (ds_if.en) begin
      pending_d = 1'b0;
      if (last_step) begin
        st_d = '0;
        ch_d = last_ch ? '0 : ch_q + 1'b1;
      end else begin
        st_d = st_q + 1'b1;
      end
      if (st_q == '0) begin
        acc_d = {{(AccW-IN_BITS){1'b0}}, u_sel};
        // Taps are captured once per frame so they never change mid-frame.
        if (ch_q == '0) begin
          for (int k = 0; k < ORDER; k++) begin
            coeff_d[k] = ds_if.coeffs[k*COEFF_BITS +: COEFF_BITS];
          end
        end
      end else begin
        acc_d = acc_sum;
      end
      if (last_step) begin
        y_d       = y_new;
        y_ch_d    = ch_q;
        y_sat_d   = sat_new;
        pending_d = 1'b1;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          if (ch_q == ChW'(c)) begin
            for (int k = ORDER - 1; k >= 1; k--) e_d[c][k] = e_q[c][k-1];
            e_d[c][0] = e_new;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= '0;
      ch_q      <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_ch_q    <= '0;
      y_sat_q   <= 1'b0;
      pending_q <= 1'b0;
      for (int k = 0; k < ORDER; k++) coeff_q[k] <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        for (int k = 0; k < ORDER; k++) e_q[c][k] <= '0;
      end
    end else begin
      st_q      <= st_d;
      ch_q      <= ch_d;
      acc_q     <= acc_d;
      coeff_q   <= coeff_d;
      e_q       <= e_d;
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
      y_sat_q   <= y_sat_d;
      pending_q <= pending_d;
    end
  end

  // A completed code is held pending until an enabled cycle, so a disabled cycle defers it.
  assign ds_if.y_valid   = pending_q & ds_if.en & ~reset;
  assign ds_if.y         = y_q;
  assign ds_if.y_channel = y_ch_q;
  assign ds_if.y_sat     = y_sat_q;

endmodule

// File: doc/multichannel_ds_modulator.md
# multichannel_ds_modulator

Time-multiplexed, parametrised error-feedback delta-sigma modulator serving `NUM_CHANNELS` independent audio channels with a programmable noise-transfer function of order `ORDER`. It generalises the single-channel modulator: one shared datapath, per-channel error history, runtime integer NTF coefficients, a saturation flag and an optional LFSR dither. It sits between the sample source and the per-channel PWM/output stage, producing one tagged `OUT_BITS` code per channel per frame.

## Interface
- `NUM_CHANNELS`, 2: number of channels (≥1).
- `ORDER`, 3: number of error-feedback taps (≥1).
- `IN_BITS`, 16: unsigned input width.
- `FRAC_BITS`, 8: bits removed by the quantiser (1 ≤ FRAC_BITS < IN_BITS).
- `OUT_BITS`, 9: unsigned output width.
- `COEFF_BITS`, 3: signed width of each feedback coefficient.
- `clk` in 1: clock; the block has one clock.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: advance enable; low freezes all state.
- `u` in NUM_CHANNELS*IN_BITS: channel c at `[c*IN_BITS +: IN_BITS]`, unsigned.
- `coeffs` in ORDER*COEFF_BITS: signed tap c_k (k=1..ORDER) at `[(k-1)*COEFF_BITS +: COEFF_BITS]`.
- `force_err` in 1: test hook, overrides stored error.
- `forced_err_value` in FRAC_BITS: value stored when `force_err` is high.
- `reset_lfsr` in 1: reloads the dither LFSR seed (ignored without dither).
- `y` out OUT_BITS: quantised output code.
- `y_channel` out max(1,$clog2(NUM_CHANNELS)): channel that `y` belongs to.
- `y_valid` out 1: one-cycle strobe qualifying `y`, `y_channel`, `y_sat`.
- `y_sat` out 1: high if the code was clamped.

## Operation
- Sequencer: channel counter `ch` (0..NUM_CHANNELS-1) and step counter `st` (0..ORDER). Advances only when `en`=1; `st` wraps to 0 and increments `ch` (wrapping to 0) after step ORDER.
- Step 0 of channel 0: latch `coeffs` into shadow registers. Coefficients never change mid-frame.
- Step 0: acc ← zero-extended `u[ch]` (sampled this cycle only).
- Step k (1..ORDER): acc ← acc + c_k·e[ch][k], where e[ch][1] is the most recent error of that channel.
- Step ORDER, after the addition: w = acc (+ dither if enabled). Quantise: q = w >>> FRAC_BITS (arithmetic). y = 0 with y_sat=1 if q<0; y = 2^OUT_BITS−1 with y_sat=1 if q>2^OUT_BITS−1; else y=q, y_sat=0. Error e_new = w[FRAC_BITS-1:0] (unsigned, always from unclamped w), or `forced_err_value` if `force_err`=1 in that cycle. Shift channel history: e[ch][k+1] ← e[ch][k], e[ch][1] ← e_new.
- NTF = 1 − Σ c_k z^−k; e.g. c1=2, c2=−1 gives (1−z^−1)^2.
- acc is signed, IN_BITS+COEFF_BITS+$clog2(ORDER+1)+2 bits; no overflow is possible for any input.
- Reset: ch=0, st=0, acc=0, all histories 0, shadow coeffs 0, y=0, y_channel=0, y_valid=0, y_sat=0, LFSR=seed.

## Timing
- Per channel: ORDER+1 enabled cycles; frame: NUM_CHANNELS·(ORDER+1) enabled cycles.
- `y`, `y_channel`, `y_sat` are registered at the end of step ORDER; `y_valid` is high the following cycle for exactly one cycle. The outputs hold until the next strobe.
- First strobe after reset release with `en`=1 throughout: cycle ORDER+1 (cycle 0 = first cycle after reset low), channel 0.
- `en` low: no state changes and `y_valid`=0. A strobe due in that cycle is deferred to the first enabled cycle.
- Reset mid-frame discards the partial sample; no strobe is issued for it.
- `reset` overrides `en`.

## Configuration
- `DS_DITHER_EN` defined: 16-bit Galois LFSR, polynomial mask 0xB400, seed 0xACE1. It advances once per quantisation (step ORDER, `en`=1). `reset` or `reset_lfsr` reloads the seed; `reset_lfsr` takes priority over advance. Dither d = lfsr[FRAC_BITS-1:0] − 2^(FRAC_BITS−1) is added to w before quantisation.
- Not defined: no LFSR, d=0, `reset_lfsr` unused, and the output is bit-exact deterministic per the equations above.

## Test plan
- Setup: NUM_CHANNELS=2, ORDER=2, others default, no dither.
- Reset held 3 cycles, then `en`=1, coeffs 0, u0=0x1234: all outputs 0 during reset; first `y_valid` at cycle 3 with y=0x12, y_channel=0, y_sat=0; ch1 strobe 3 cycles later.
- c1=1, c2=0, u0=0x0180, u1=0x0040: ch0 yields 1,2,1,2,…; ch1 yields 0,0,0,1 repeating. This verifies independent histories.
- c1=−4, u0=0, `force_err`=1 with 0xFF for one ch0 quantisation: next ch0 sample has w=−1020, giving y=0 and y_sat=1.
- Toggle `en` low for 5 cycles at ch0 step 1: no strobes during the gap, and the sequence resumes identically (same y values, period extends by 5).
- `reset` pulse at ch1 step 1 with c1=1 running: next strobe is ch0 at cycle 3 after release, and its value equals a fresh-start value (history cleared).
